shift_cmd_ctrl: RTL
===================

# shift_cmd_ctrl

Command sequencer that drives a SIZE-bit universal shift register: parallel load, clear, shift left or right, and rotate left or right by a programmed count. It accepts one command at a time over a valid/ready handshake and drives the register's mode and serial-in bit one operation per cycle. When the command finishes it samples the register's parallel output and returns it as a one-cycle result. It sits between the control/CPU-side logic and the shift-register datapath; the register itself is external.

## Interface
- SIZE, 4: width of the controlled shift register (≥2).
- CNT_W, 5: width of the shift-count field; maximum count is 2^CNT_W-1.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  3  opcode: 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 CLEAR, 111 illegal.
- cmd_cnt  in  CNT_W  shift/rotate count; ignored for NOP, LOAD and CLEAR.
- cmd_fill  in  1  serial fill bit for SHL and SHR.
- cmd_data  in  SIZE  parallel load value for LOAD.
- abort  in  1  synchronous stop of a running shift/rotate.
- sr_mode  out  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_sin  out  1  serial-in bit to the register.
- sr_pdata  out  SIZE  parallel-load value to the register.
- sr_q  in  SIZE  register parallel output.
- busy  out  1  high in any state except IDLE.
- res_valid  out  1  one-cycle pulse when a command completes.
- res_data  out  SIZE  register value sampled at completion.
- res_err  out  1  qualifies res_valid: opcode was illegal.
- res_abort  out  1  qualifies res_valid: command was aborted.

## Operation
- Handshake: a command is accepted on a rising edge where cmd_valid and cmd_ready are both high. The controller latches op, cnt, fill and data on that edge.
- States: IDLE, EXEC, CAP.
- Transitions out of IDLE on accept:
  - SHL/SHR/ROL/ROR with cnt>0 go to EXEC, with the remaining-count register set to cnt.
  - LOAD and CLEAR go to EXEC for exactly one cycle.
  - NOP, cnt==0 shifts, and the illegal opcode go directly to CAP.
- EXEC drives one register operation per cycle:
  - SHL: sr_mode=10, sr_sin=fill.
  - SHR: sr_mode=01, sr_sin=fill.
  - ROL: sr_mode=10, sr_sin=sr_q[SIZE-1].
  - ROR: sr_mode=01, sr_sin=sr_q[0].
  - LOAD: sr_mode=11, sr_pdata=data.
  - CLEAR: sr_mode=11, sr_pdata=0.
- The rotate sr_sin is combinational from sr_q.
- The remaining count decrements on each EXEC edge. When it reaches 1, the next state is CAP.
- Counts greater than SIZE are legal and are executed in full; for example, SHL by SIZE+2 with fill 0 yields all zeros.
- CAP: sr_mode=00. On the edge leaving CAP the controller sets res_data <= sr_q, sets res_err/res_abort, pulses res_valid, and returns to IDLE.
- abort high in EXEC: the current cycle's operation is suppressed (sr_mode=00) and the next state is CAP with res_abort=1. abort is ignored in IDLE and CAP.
- Outside EXEC: sr_mode=00, sr_sin=0, sr_pdata=0.

## Timing
- Reset (rst low, asynchronous) forces:
  - state=IDLE
  - cmd_ready=1
  - busy=0
  - sr_mode=00, sr_sin=0, sr_pdata=0
  - res_valid=0, res_data=0, res_err=0, res_abort=0
- Reset mid-command discards the command. No res_valid is issued for it.
- Latency is counted from the accept edge A to the cycle in which res_valid is high:
  - Shift/rotate by N≥1: EXEC occupies the cycles after A through A+N, CAP occupies cycle A+N+1, and res_valid is high in cycle A+N+2.
  - LOAD/CLEAR: res_valid in cycle A+3.
  - NOP, cnt==0 or illegal: res_valid in cycle A+2.
- cmd_ready rises in the same cycle as res_valid. A new command may be accepted at the end of that cycle, so back-to-back throughput is latency+0.
- busy = !cmd_ready.
- res_data, res_err and res_abort hold their values until the next completion. Only res_valid is a pulse.
- Abort asserted in the k-th EXEC cycle leaves exactly k-1 operations applied.

## Test plan
- Reset/idle: rst low with random inputs -> all outputs at reset values. After release, cmd_ready=1 and sr_mode=00.
- LOAD then SHL: LOAD 4'b1001, then SHL cnt=2 fill=1 -> res_data 1001, then 0111. Exactly 2 cycles with sr_mode=10, and res_valid in cycle A+4.
- Rotate: starting from 1001, ROR cnt=1 gives 1100; ROL cnt=5 gives 1001, returning to the start value because 5 mod 4 = 1 relative to 1100. Verify that sr_sin equals the wrapped bit each cycle.
- Boundary: SHR cnt=0 gives res_valid at A+2 with data unchanged and no shift cycles. SHL cnt=31 fill=0 gives 0000.
- Abort: SHL cnt=10 fill=1 from 0000, abort during the 3rd EXEC cycle -> res_abort=1, res_data=0011.
- Illegal and reset: op=111 -> res_err=1 with data unchanged. rst pulsed low mid-SHR -> no res_valid, and a new command is accepted normally.

Source files
------------

// File: rtl/shift_cmd_if.sv
// Command/result channel between the CPU-side logic and the shift-register
// sequencer: valid/ready command, abort, and a one-cycle result pulse.
interface shift_cmd_if #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_fill;
  logic [SIZE-1:0]  cmd_data;
  logic             abort;
  logic             busy;
  logic             res_valid;
  logic [SIZE-1:0]  res_data;
  logic             res_err;
  logic             res_abort;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data, abort,
    input  cmd_ready, busy, res_valid, res_data, res_err, res_abort
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data, abort,
    output cmd_ready, busy, res_valid, res_data, res_err, res_abort
  );
endinterface

// File: rtl/shift_cmd_ctrl.sv
// Sequencer for an external universal shift register: runs one load, clear,
// shift or rotate command at a time and returns the register value on completion.
module shift_cmd_ctrl #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  shift_cmd_if.slave      bus,
  output logic [1:0]      sr_mode,
  output logic            sr_sin,
  output logic [SIZE-1:0] sr_pdata,
  input  logic [SIZE-1:0] sr_q
);

  typedef enum logic [1:0] {IDLE, EXEC, CAP} state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_CLEAR = 3'b110,
    OP_ILL   = 3'b111
  } op_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_e           state;
  op_e              op_q;
  logic             fill_q;
  logic [SIZE-1:0]  data_q;
  logic [CNT_W-1:0] rem_q;
  logic             err_q;
  logic             abort_q;

  op_e  cmd_op;
  logic accept;
  logic cmd_is_shift;

  assign cmd_op       = op_e'(bus.cmd_op);
  assign accept       = bus.cmd_valid && bus.cmd_ready;
  assign cmd_is_shift = cmd_op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR};

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_q          <= OP_NOP;
      fill_q        <= 1'b0;
      data_q        <= '0;
      rem_q         <= '0;
      err_q         <= 1'b0;
      abort_q       <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_err   <= 1'b0;
      bus.res_abort <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= cmd_op;
            fill_q  <= bus.cmd_fill;
            data_q  <= bus.cmd_data;
            err_q   <= (cmd_op == OP_ILL);
            abort_q <= 1'b0;
            if (cmd_is_shift && bus.cmd_cnt != '0) begin
              rem_q <= bus.cmd_cnt;
              state <= EXEC;
            end else if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
              rem_q <= CNT_W'(1);
              state <= EXEC;
            end else begin
              state <= CAP;
            end
          end
        end
        EXEC: begin
          rem_q <= rem_q - 1'b1;
          if (bus.abort) begin
            abort_q <= 1'b1;
            state   <= CAP;
          end else if (rem_q == CNT_W'(1)) begin
            state <= CAP;
          end
        end
        CAP: begin
          // The register is held in CAP, so sr_q is the final value here.
          bus.res_data  <= sr_q;
          bus.res_err   <= err_q;
          bus.res_abort <= abort_q;
          bus.res_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register drive is combinational so abort can suppress the current cycle
  // and the rotate wrap bit follows sr_q directly.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    sr_mode  = MODE_HOLD;
    sr_sin   = 1'b0;
    sr_pdata = '0;
    if (state == EXEC && !bus.abort) begin
      case (op_q)
        OP_SHL: begin
          sr_mode = MODE_SHL;
          sr_sin  = fill_q;
        end
        OP_SHR: begin
          sr_mode = MODE_SHR;
          sr_sin  = fill_q;
        end
        OP_ROL: begin
          sr_mode = MODE_SHL;
          sr_sin  = sr_q[SIZE-1];
        end
        OP_ROR: begin
          sr_mode = MODE_SHR;
          sr_sin  = sr_q[0];
        end
        OP_LOAD: begin
          sr_mode  = MODE_LOAD;
          sr_pdata = data_q;
        end
        OP_CLEAR: sr_mode = MODE_LOAD;
        default: ;
      endcase
    end
  end

endmodule
